button_cond: RTL and testbench

BUTTON_COND -- requirements
Module: button_cond

---
 rtl/button_cond.sv | 139 +++++++++++++
 tb/tb_button_cond.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_cond.sv
// button_cond: synchronizes, debounces and edge-detects four board push-buttons.
// Optional power-on reset stretch on button_r is enabled by defining BUTTON_POR_EN.
`default_nettype none

module button_cond #(
  parameter int TICK_DIV   = 50000,
  parameter int STABLE_CNT = 16,
  parameter int POR_TICKS  = 64
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic raw_r,
  input  logic raw_b,
  input  logic raw_h,
  input  logic raw_c,
  output logic button_r,
  output logic button_b,
  output logic button_h,
  output logic button_c,
  output logic press_r,
  output logic press_b,
  output logic press_h,
  output logic press_c,
  output logic por_busy
);

  localparam int              TW        = $clog2(TICK_DIV);
  localparam int              CW        = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   CNT_DONE  = CW'(STABLE_CNT);

  // Bit order everywhere: {c, h, b, r}
  logic [3:0]          raw_vec;
  logic [3:0]          meta_d, meta_q;
  logic [3:0]          sync_d, sync_q;
  logic [TW-1:0]       tick_cnt_d, tick_cnt_q;
  logic                tick;
  logic [3:0][CW-1:0]  cnt_d, cnt_q;
  logic [CW-1:0]       cnt_inc;
  logic [3:0]          deb_d, deb_q;
  logic [3:0]          press_d, press_q;

  assign raw_vec = {raw_c, raw_h, raw_b, raw_r};

  always_comb begin
    meta_d     = raw_vec;
    sync_d     = meta_q;
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    cnt_d      = cnt_q;
    deb_d      = deb_q;
    press_d    = '0;
    cnt_inc    = '0;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (sync_q[i] != deb_q[i]) begin
          cnt_inc = cnt_q[i] + 1'b1;
          // Counter is cleared on acceptance, so it never passes STABLE_CNT.
          if (cnt_inc == CNT_DONE) begin
            deb_d[i]   = sync_q[i];
            cnt_d[i]   = '0;
            press_d[i] = sync_q[i];
          end else begin
            cnt_d[i] = cnt_inc;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q     <= '0;
      sync_q     <= '0;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      deb_q      <= '0;
      press_q    <= '0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      press_q    <= press_d;
    end
  end

`ifdef BUTTON_POR_EN
  localparam int            PW       = $clog2(POR_TICKS + 1);
  localparam logic [PW-1:0] POR_DONE = PW'(POR_TICKS);

  logic [PW-1:0] por_cnt_d, por_cnt_q;
  logic          por_busy_d, por_busy_q;

  always_comb begin
    por_cnt_d  = por_cnt_q;
    por_busy_d = por_busy_q;
    if (por_busy_q && tick) begin
      if (por_cnt_q + 1'b1 == POR_DONE) begin
        por_busy_d = 1'b0;
        por_cnt_d  = '0;
      end else begin
        por_cnt_d = por_cnt_q + 1'b1;
      end
    end
  end

  // Stretch is armed by reset itself so it is active from the first cycle after release.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      por_cnt_q  <= '0;
      por_busy_q <= 1'b1;
    end else begin
      por_cnt_q  <= por_cnt_d;
      por_busy_q <= por_busy_d;
    end
  end

  assign por_busy = por_busy_q;
  assign button_r = deb_q[0] | por_busy_q;
`else
  assign por_busy = 1'b0;
  assign button_r = deb_q[0];
`endif

  assign button_b = deb_q[1];
  assign button_h = deb_q[2];
  assign button_c = deb_q[3];
  assign press_r  = press_q[0];
  assign press_b  = press_q[1];
  assign press_h  = press_q[2];
  assign press_c  = press_q[3];

endmodule

`default_nettype wire

// File: tb/tb_button_cond.sv
// Self-checking bench for button_cond with TICK_DIV=4, STABLE_CNT=3, POR_TICKS=5.
`timescale 1ns/1ps
`default_nettype none

module tb_button_cond;

  localparam int TICK_DIV   = 4;
  localparam int STABLE_CNT = 3;
  localparam int POR_TICKS  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_r = 1'b0, raw_b = 1'b0, raw_h = 1'b0, raw_c = 1'b0;
  logic button_r, button_b, button_h, button_c;
  logic press_r, press_b, press_h, press_c;
  logic por_busy;

  always #5 clk = ~clk;

  button_cond #(
    .TICK_DIV  (TICK_DIV),
    .STABLE_CNT(STABLE_CNT),
    .POR_TICKS (POR_TICKS)
  ) dut (
    .sysclk  (clk),
    .reset_n (reset_n),
    .raw_r   (raw_r),
    .raw_b   (raw_b),
    .raw_h   (raw_h),
    .raw_c   (raw_c),
    .button_r(button_r),
    .button_b(button_b),
    .button_h(button_h),
    .button_c(button_c),
    .press_r (press_r),
    .press_b (press_b),
    .press_h (press_h),
    .press_c (press_c),
    .por_busy(por_busy)
  );

  logic [3:0] btn, prs;
  assign btn = {button_c, button_h, button_b, button_r};
  assign prs = {press_c, press_h, press_b, press_r};

  typedef struct {
    string      name;
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_btn;
    logic [3:0] exp_press;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];

  int total = 0;
  int bad   = 0;

  // Edges since reset release; tick edges are those where cyc % TICK_DIV == 0.
  int cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  int press_cnt[4];
  int h_high_cnt;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) press_cnt[i] <= press_cnt[i] + (prs[i] ? 1 : 0);
    if (button_h) h_high_cnt <= h_high_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive_raw(input logic [3:0] v);
    {raw_c, raw_h, raw_b, raw_r} = v;
  endtask

  task automatic align_tick();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % TICK_DIV != 0);
  endtask

  initial begin
    int snap[4];
    int n, n_busy, n_diff, p0, h0;
    vec_t e;

    vecs[0]  = '{"r_on",     4'b0001, 24, 4'b0001, 4'b0001};
    vecs[1]  = '{"b_on",     4'b0011, 24, 4'b0011, 4'b0010};
    vecs[2]  = '{"all_on",   4'b1111, 24, 4'b1111, 4'b1100};
    vecs[3]  = '{"all_off",  4'b0000, 24, 4'b0000, 4'b0000};
    vecs[4]  = '{"glitch2",  4'b0101,  2, 4'b0000, 4'b0000};
    vecs[5]  = '{"settle_a", 4'b0000, 24, 4'b0000, 4'b0000};
    vecs[6]  = '{"short6",   4'b1010,  6, 4'b0000, 4'b0000};
    vecs[7]  = '{"settle_b", 4'b0000, 24, 4'b0000, 4'b0000};
    vecs[8]  = '{"bc_on",    4'b1010, 24, 4'b1010, 4'b1010};
    vecs[9]  = '{"swap",     4'b0101, 24, 4'b0101, 4'b0101};
    vecs[10] = '{"off_end",  4'b0000, 24, 4'b0000, 4'b0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_btn_bhc", int'(btn[3:1]), 0);
    check("rst_press", int'(prs), 0);
`ifdef BUTTON_POR_EN
    check("rst_btn_r", int'(button_r), 1);
`else
    check("rst_btn_r", int'(button_r), 0);
    check("rst_por_busy", int'(por_busy), 0);
`endif

    // Power-on stretch window
    @(posedge clk);
    #1 reset_n = 1'b1;
    p0 = press_cnt[0];
    n_busy = 0;
    n_diff = 0;
    repeat (40) begin
      @(negedge clk);
      if (por_busy) n_busy++;
      if (button_r !== por_busy) n_diff++;
    end
    #1;
`ifdef BUTTON_POR_EN
    check_range("por_len", n_busy, 16, 24);
`else
    check("por_len", n_busy, 0);
`endif
    check("por_btn_r_tracks", n_diff, 0);
    check("por_no_press_r", press_cnt[0] - p0, 0);
    check("por_end", int'(por_busy), 0);

    // Table-driven vectors through the scoreboard queue
    for (int v = 0; v < 11; v++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) snap[i] = press_cnt[i];
      drive_raw(vecs[v].raw);
      sb_q.push_back(vecs[v]);
      repeat (vecs[v].hold) @(negedge clk);
      #1;
      if (sb_q.size() == 0) begin
        check("sb_empty", 0, 1);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_btn"}, int'(btn), int'(e.exp_btn));
        for (int i = 0; i < 4; i++)
          check($sformatf("%s_press%0d", e.name, i), press_cnt[i] - snap[i], int'(e.exp_press[i]));
      end
    end

    // Press latency from a tick boundary, single-cycle strobe, no release strobe
    align_tick();
    snap[1] = press_cnt[1];
    raw_b = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!button_b && n < 40);
    check_range("b_latency", n, 10, 18);
    repeat (5) @(negedge clk);
    #1;
    check("b_press_once", press_cnt[1] - snap[1], 1);
    @(posedge clk);
    #1 raw_b = 1'b0;
    repeat (24) @(negedge clk);
    #1;
    check("b_released", int'(button_b), 0);
    check("b_no_release_strobe", press_cnt[1] - snap[1], 1);

    // Bouncing raw_h never qualifies
    h0 = h_high_cnt;
    snap[2] = press_cnt[2];
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      raw_h = (k % 2 == 0);
      repeat (5) @(posedge clk);
      #1;
    end
    raw_h = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("h_bounce_level", h_high_cnt - h0, 0);
    check("h_bounce_press", press_cnt[2] - snap[2], 0);

    // Simultaneous r and c
    @(posedge clk);
    #1;
    raw_r = 1'b1;
    raw_c = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!button_r && !button_c && n < 40);
    check("rc_btn_together", int'({button_c, button_r}), 3);
    check("rc_press_together", int'({press_c, press_r}), 3);
    @(posedge clk);
    #1;
    raw_r = 1'b0;
    raw_c = 1'b0;
    repeat (24) @(negedge clk);

    // Reset in the middle of a qualification
    align_tick();
    snap[3] = press_cnt[3];
    raw_c = 1'b1;
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("c_abort_level", int'(button_c), 0);
    check("c_abort_press", int'(press_c), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!button_c && n < 40);
    check_range("c_restart_latency", n, 11, 15);
    repeat (5) @(negedge clk);
    #1;
    check("c_press_once", press_cnt[3] - snap[3], 1);
    raw_c = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
